// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin arbiter for a pipelined Wishbone B4 slave port.
// Grants whole CYC tenures and caps accepted-but-unacked requests at MAX_OUTSTANDING.
module wb_rr_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int SEL_W           = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [SEL_W-1:0]  m0_sel_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic              m0_stall_o,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_dat_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic              m1_stall_o,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic              s_stall_i,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_dat_i
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state, state_nxt;
    logic last_owner, last_owner_nxt;
    logic [CNT_W-1:0] outst, outst_nxt;
    logic own0, own1, throttle, acc, dec;

    assign own0     = state == OWN0;
    assign own1     = state == OWN1;
    assign throttle = outst == MAX_CNT;

    assign s_cyc_o = own0 ? m0_cyc_i : own1 ? m1_cyc_i : 1'b0;
    assign s_stb_o = s_cyc_o && !throttle && (own1 ? m1_stb_i : m0_stb_i);
    assign s_we_o  = (own0 && m0_we_i) || (own1 && m1_we_i);
    assign s_adr_o = own0 ? m0_adr_i : own1 ? m1_adr_i : '0;
    assign s_sel_o = own0 ? m0_sel_i : own1 ? m1_sel_i : '0;
    assign s_dat_o = own0 ? m0_dat_i : own1 ? m1_dat_i : '0;

    assign m0_stall_o = !own0 || s_stall_i || throttle;
    assign m1_stall_o = !own1 || s_stall_i || throttle;
    // Gating with s_cyc_o drops acks that arrive after the owner released
    assign m0_ack_o   = own0 && s_ack_i && s_cyc_o;
    assign m1_ack_o   = own1 && s_ack_i && s_cyc_o;
    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;

    assign acc = s_stb_o && !s_stall_i;
    assign dec = s_ack_i && s_cyc_o;

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        outst_nxt      = outst;
        if (acc && !dec)
            outst_nxt = outst + CNT_W'(1);
        else if (dec && !acc && outst != '0)
            outst_nxt = outst - CNT_W'(1);
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i)
                    state_nxt = last_owner ? OWN0 : OWN1;
                else if (m0_cyc_i)
                    state_nxt = OWN0;
                else if (m1_cyc_i)
                    state_nxt = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    state_nxt      = m1_cyc_i ? OWN1 : IDLE;
                    last_owner_nxt = 1'b0;
                    outst_nxt      = '0;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    state_nxt      = m0_cyc_i ? OWN0 : IDLE;
                    last_owner_nxt = 1'b1;
                    outst_nxt      = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            outst      <= '0;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            outst      <= outst_nxt;
        end
    end
endmodule
